// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared FSM/edge types, counter widths, saturation limits and the
// 1280x800 raster constants used by both the timing generator and the receiver.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    typedef enum logic [1:0] {
        EV_NONE     = 2'd0,
        EV_ASSERT   = 2'd1,
        EV_DEASSERT = 2'd2
    } sync_ev_t;

    localparam int H_CNT_W = 12;
    localparam int V_CNT_W = 11;

    localparam logic [H_CNT_W-1:0] H_CNT_MAX = 12'd4095;
    localparam logic [V_CNT_W-1:0] V_CNT_MAX = 11'd2047;

    localparam int VGA_H_DISPLAY   = 1280;
    localparam int VGA_H_SYNC      = 128;
    localparam int VGA_H_SYNC_BACK = 328;
    localparam int VGA_H_TOTAL     = 1680;
    localparam int VGA_V_DISPLAY   = 800;
    localparam int VGA_V_SYNC_BACK = 28;
    localparam int VGA_V_TOTAL     = 831;
    localparam int VGA_LOCK_FRAMES = 2;

    function automatic logic [H_CNT_W-1:0] h_sat_inc(input logic [H_CNT_W-1:0] v);
        if (v == H_CNT_MAX) return v;
        else return v + 12'd1;
    endfunction

    function automatic logic [V_CNT_W-1:0] v_sat_inc(input logic [V_CNT_W-1:0] v);
        if (v == V_CNT_MAX) return v;
        else return v + 11'd1;
    endfunction

endpackage

// File: rtl/vga_sync_receiver_if.sv
// vga_sync_receiver_if: incoming sync pair plus everything the receiver reports.
// master = sync source / consumer side, slave = the receiver.
interface vga_sync_receiver_if;
    import vga_rx_pkg::*;

    logic               hsync;
    logic               vsync;
    logic               locked;
    logic               pix_valid;
    logic [10:0]        pix_x;
    logic [9:0]         pix_y;
    logic               frame_start;
    logic [H_CNT_W-1:0] h_total_meas;
    logic [H_CNT_W-1:0] h_sync_meas;
    logic [V_CNT_W-1:0] v_total_meas;
    logic               sync_err;

    modport master (
        output hsync, vsync,
        input  locked, pix_valid, pix_x, pix_y, frame_start,
        input  h_total_meas, h_sync_meas, v_total_meas, sync_err
    );

    modport slave (
        input  hsync, vsync,
        output locked, pix_valid, pix_x, pix_y, frame_start,
        output h_total_meas, h_sync_meas, v_total_meas, sync_err
    );
endinterface

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: normalises one sync pin to asserted-high, samples it once and
// reports assert/deassert transitions of the sampled level as a one-cycle event.
module vga_sync_edge
    import vga_rx_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     sync_in,
    output sync_ev_t sync_ev
);

    logic norm_s;
    logic sample_r;
    logic prev_r;

    // Map the pin onto an asserted-high level whatever the link polarity.
    always_comb begin
        norm_s = sync_in;
        if (ACTIVE_LOW != 0) norm_s = ~sync_in;
        else norm_s = sync_in;
    end

    // Single sample register plus one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_r <= 1'b0;
            prev_r   <= 1'b0;
        end else begin
            sample_r <= norm_s;
            prev_r   <= sample_r;
        end
    end

    // Classify the sampled level change; assert and deassert are exclusive.
    always_comb begin
        sync_ev = EV_NONE;
        if (sample_r && !prev_r) sync_ev = EV_ASSERT;
        else if (!sample_r && prev_r) sync_ev = EV_DEASSERT;
        else sync_ev = EV_NONE;
    end

endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers VGA raster timing from hsync/vsync, locks after
// LOCK_FRAMES clean identical frames and regenerates pixel coordinates.
// Optional feature macro: VGA_RX_ERR_COUNT_EN adds a 16-bit saturating
// err_count port counting sync_err pulses (cleared only by reset).
module vga_sync_receiver
    import vga_rx_pkg::*;
#(
    parameter int H_DISPLAY       = VGA_H_DISPLAY,
    parameter int H_SYNC_BACK     = VGA_H_SYNC_BACK,
    parameter int V_DISPLAY       = VGA_V_DISPLAY,
    parameter int V_SYNC_BACK     = VGA_V_SYNC_BACK,
    parameter int LOCK_FRAMES     = VGA_LOCK_FRAMES,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               reset,
    vga_sync_receiver_if.slave bus
`ifdef VGA_RX_ERR_COUNT_EN
    ,
    output logic [15:0]        err_count
`endif
);

    localparam logic [11:0] H_LO     = 12'(H_SYNC_BACK);
    localparam logic [11:0] H_HI     = 12'(H_SYNC_BACK + H_DISPLAY);
    localparam logic [10:0] V_LO     = 11'(V_SYNC_BACK);
    localparam logic [10:0] V_HI     = 11'(V_SYNC_BACK + V_DISPLAY);
    localparam logic [2:0]  LOCK_TGT = 3'(LOCK_FRAMES);

    sync_ev_t    h_ev_s, v_ev_s;
    logic        h_start_s, h_end_s, v_start_s;
    rx_state_t   state_r, state_nx_s;
    logic [11:0] h_cnt_r, h_cnt_nx_s, line_len_s, h_total_r, h_sync_r;
    logic [10:0] v_line_r, v_line_nx_s, frame_len_s, v_total_r;
    logic [2:0]  match_cnt_r, match_inc_s;
    logic        have_ref_r, clean_r;
    logic        sat_s, line_bad_s, frame_ok_s, lock_err_s, pix_valid_nx_s;
    logic        locked_r, pix_valid_r, frame_start_r, sync_err_r;
    logic [10:0] pix_x_r;
    logic [9:0]  pix_y_r;

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_h_edge (
        .clk(clk), .reset(reset), .sync_in(bus.hsync), .sync_ev(h_ev_s)
    );

    vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_v_edge (
        .clk(clk), .reset(reset), .sync_in(bus.vsync), .sync_ev(v_ev_s)
    );

    // Decode sync events, compute next counter values and the line/frame checks.
    always_comb begin
        h_start_s   = (h_ev_s == EV_ASSERT);
        h_end_s     = (h_ev_s == EV_DEASSERT);
        v_start_s   = (v_ev_s == EV_ASSERT);
        line_len_s  = h_cnt_r + 12'd1;
        match_inc_s = match_cnt_r + 3'd1;
        frame_len_s = v_line_r;
        h_cnt_nx_s  = h_cnt_r;
        v_line_nx_s = v_line_r;
        // A frame boundary landing on a line start still counts that line.
        if (h_start_s) frame_len_s = v_line_r + 11'd1;
        else frame_len_s = v_line_r;
        if (h_start_s) h_cnt_nx_s = 12'd0;
        else h_cnt_nx_s = h_sat_inc(h_cnt_r);
        if (v_start_s) v_line_nx_s = 11'd0;
        else if (h_start_s) v_line_nx_s = v_sat_inc(v_line_r);
        else v_line_nx_s = v_line_r;
        sat_s      = (h_cnt_r == H_CNT_MAX) || (v_line_r == V_CNT_MAX);
        line_bad_s = h_start_s && have_ref_r && (line_len_s != h_total_r);
        frame_ok_s = clean_r && !line_bad_s && (frame_len_s == v_total_r);
        lock_err_s = (state_r == LOCKED) &&
                     ((h_start_s && (line_len_s != h_total_r)) ||
                      (v_start_s && (frame_len_s != v_total_r)) || sat_s);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= SEARCH;
        else state_r <= state_nx_s;
    end

    // FSM next-state: search for a frame edge, measure until stable, hold lock.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            SEARCH: begin
                if (v_start_s) state_nx_s = MEASURE;
                else state_nx_s = SEARCH;
            end
            MEASURE: begin
                if (sat_s) state_nx_s = SEARCH;
                else if (v_start_s && frame_ok_s && (match_inc_s >= LOCK_TGT)) state_nx_s = LOCKED;
                else state_nx_s = MEASURE;
            end
            LOCKED: begin
                if (lock_err_s) state_nx_s = SEARCH;
                else state_nx_s = LOCKED;
            end
            default: state_nx_s = SEARCH;
        endcase
    end

    // Coordinates use next-cycle counter values so the registered outputs lag the source by two clocks.
    always_comb begin
        pix_valid_nx_s = 1'b0;
        if ((state_nx_s == LOCKED) && (h_cnt_nx_s >= H_LO) && (h_cnt_nx_s < H_HI) &&
            (v_line_nx_s >= V_LO) && (v_line_nx_s < V_HI)) pix_valid_nx_s = 1'b1;
        else pix_valid_nx_s = 1'b0;
    end

    // Raster counters, sync width capture, line reference and frame-match tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_r     <= 12'd0;
            v_line_r    <= 11'd0;
            h_sync_r    <= 12'd0;
            h_total_r   <= 12'd0;
            v_total_r   <= 11'd0;
            match_cnt_r <= 3'd0;
            have_ref_r  <= 1'b0;
            clean_r     <= 1'b0;
        end else begin
            h_cnt_r  <= h_cnt_nx_s;
            v_line_r <= v_line_nx_s;
            if (h_end_s) h_sync_r <= line_len_s;
            case (state_r)
                SEARCH: begin
                    match_cnt_r <= 3'd0;
                    have_ref_r  <= 1'b0;
                    clean_r     <= 1'b1;
                end
                MEASURE: begin
                    if (h_start_s && !have_ref_r) begin
                        h_total_r  <= line_len_s;
                        have_ref_r <= 1'b1;
                    end else if (line_bad_s) begin
                        clean_r <= 1'b0;
                    end
                    // Frame boundary: record length, then count a match or start over.
                    if (v_start_s) begin
                        v_total_r <= frame_len_s;
                        clean_r   <= 1'b1;
                        if (frame_ok_s) begin
                            match_cnt_r <= match_inc_s;
                        end else begin
                            match_cnt_r <= 3'd0;
                            have_ref_r  <= 1'b0;
                        end
                    end
                end
                LOCKED: begin
                    clean_r <= 1'b1;
                end
                default: begin
                    match_cnt_r <= 3'd0;
                    have_ref_r  <= 1'b0;
                end
            endcase
        end
    end

    // Registered status and pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_r      <= 1'b0;
            sync_err_r    <= 1'b0;
            frame_start_r <= 1'b0;
            pix_valid_r   <= 1'b0;
            pix_x_r       <= 11'd0;
            pix_y_r       <= 10'd0;
        end else begin
            locked_r      <= (state_nx_s == LOCKED);
            sync_err_r    <= lock_err_s;
            frame_start_r <= v_start_s && (state_r == LOCKED) && (state_nx_s == LOCKED);
            pix_valid_r   <= pix_valid_nx_s;
            if (pix_valid_nx_s) begin
                pix_x_r <= 11'(h_cnt_nx_s - H_LO);
                pix_y_r <= 10'(v_line_nx_s - V_LO);
            end else begin
                pix_x_r <= 11'd0;
                pix_y_r <= 10'd0;
            end
        end
    end

`ifdef VGA_RX_ERR_COUNT_EN
    logic [15:0] err_count_r;

    // Saturating count of lock losses.
    always_ff @(posedge clk) begin
        if (reset) err_count_r <= 16'd0;
        else if (lock_err_s && (err_count_r != 16'hFFFF)) err_count_r <= err_count_r + 16'd1;
        else err_count_r <= err_count_r;
    end

    assign err_count = err_count_r;
`endif

    assign bus.locked       = locked_r;
    assign bus.pix_valid    = pix_valid_r;
    assign bus.pix_x        = pix_x_r;
    assign bus.pix_y        = pix_y_r;
    assign bus.frame_start  = frame_start_r;
    assign bus.h_total_meas = h_total_r;
    assign bus.h_sync_meas  = h_sync_r;
    assign bus.v_total_meas = v_total_r;
    assign bus.sync_err     = sync_err_r;

endmodule
